// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage - PC, imem request handshake, IF/ID register.
// Define IF_STALL_CNT_EN to add a saturating fetch-stall cycle counter.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;

    logic        w_br;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;
    logic        w_ld_word;
    logic        w_ld_bubble;

    // A redirect only counts once the hazard unit lets ID advance.
    assign w_br     = branch_taken && IF_ID_Write;
    assign w_tgt    = {branch_target[31:2], 2'b00};
    assign w_pc_inc = r_pc + 32'd4;

    assign imem_req  = (r_state == FETCH) || (r_state == DISCARD);
    assign imem_addr = r_pc;

    always_comb begin
        w_ld_word   = 1'b0;
        w_ld_bubble = 1'b0;
        if (r_state == FETCH) begin
            if (w_br) begin
                w_ld_bubble = 1'b1;
            end else if (IF_ID_Write) begin
                w_ld_word   = imem_ready && PCWrite;
                w_ld_bubble = !(imem_ready && PCWrite);
            end
        end else if (r_state == DISCARD) begin
            w_ld_bubble = IF_ID_Write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= PC_RESET;
            r_redirect_pc <= 32'h0;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (w_br) begin
                        if (imem_ready) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_redirect_pc <= w_tgt;
                            r_state       <= DISCARD;
                        end
                    end else if (imem_ready && PCWrite) begin
                        r_pc <= w_pc_inc;
                    end
                end
                DISCARD: begin
                    // Stale word is dropped; newest redirect wins.
                    if (imem_ready) begin
                        r_pc    <= w_br ? w_tgt : r_redirect_pc;
                        r_state <= FETCH;
                    end else if (w_br) begin
                        r_redirect_pc <= w_tgt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc4   <= 32'h0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_ld_word) begin
            r_pc4   <= w_pc_inc;
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
        end else if (w_ld_bubble) begin
            r_pc4   <= 32'h0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign IF_ID_PC4   = r_pc4;
    assign IF_ID_Instr = r_instr;
    assign IF_ID_Valid = r_valid;

`ifdef IF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state != IDLE) &&
                     (!PCWrite || !IF_ID_Write || !imem_ready ||
                      (r_state == DISCARD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule
